ddr3_req_sched: RTL and testbench

Command scheduler between the AXI front-end request channels and the DDR3 memory-controller FSM. Arbitrates the independent read and write request channels onto a single command stream, batches same-direction commands to limit bus turnarounds, and generates and prioritises periodic refresh commands. One command is outstanding at a time; the downstream FSM accepts commands through a valid/ready handshake.

---
 rtl/ddr3_req_sched.sv | 182 ++++++++++++++++++
 tb/tb_ddr3_req_sched.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_req_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ddr3_req_sched                                                |
// | Purpose  : Read/write/refresh command scheduler feeding the DDR3 FSM.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ddr3_req_sched #(
  parameter int ADDR_BITS   = 25,
  parameter int ID_WIDTH    = 4,
  parameter int REFI_CYCLES = 780,
  parameter int MAX_RUN     = 4,
  parameter int REF_URGENT  = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable_i,
  input  logic                 wr_req_i,
  output logic                 wr_ack_o,
  input  logic [ID_WIDTH-1:0]  wr_tid_i,
  input  logic [ADDR_BITS-1:0] wr_adr_i,
  input  logic                 rd_req_i,
  output logic                 rd_ack_o,
  input  logic [ID_WIDTH-1:0]  rd_tid_i,
  input  logic [ADDR_BITS-1:0] rd_adr_i,
  output logic                 cmd_valid_o,
  input  logic                 cmd_ready_i,
  output logic [1:0]           cmd_op_o,
  output logic [ID_WIDTH-1:0]  cmd_tid_o,
  output logic [ADDR_BITS-1:0] cmd_adr_o,
  output logic [3:0]           ref_pend_o,
  output logic                 ref_err_o
);

  localparam int              c_TMR_W    = (REFI_CYCLES > 1) ? $clog2(REFI_CYCLES) : 1;
  localparam int              c_RUN_W    = $clog2(MAX_RUN + 1);
  localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(REFI_CYCLES - 1);
  localparam logic [c_RUN_W-1:0] c_MAX_RUN  = c_RUN_W'(MAX_RUN);
  localparam logic [3:0]      c_URGENT   = 4'(REF_URGENT);
  localparam logic [3:0]      c_PEND_MAX = 4'd8;
  localparam logic [1:0]      c_OP_RD    = 2'b00;
  localparam logic [1:0]      c_OP_WR    = 2'b01;
  localparam logic [1:0]      c_OP_REF   = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_ACK   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_cmd_valid;
  logic [1:0]            r_op;
  logic [ID_WIDTH-1:0]   r_tid;
  logic [ADDR_BITS-1:0]  r_adr;
  logic                  r_last_wr;
  logic [c_RUN_W-1:0]    r_run;
  logic [c_TMR_W-1:0]    r_timer;
  logic [3:0]            r_ref_pend;
  logic                  r_ref_err;

  logic                  w_grant;
  logic [1:0]            w_grant_op;
  logic                  w_grant_wr;
  logic                  w_hs;
  logic                  w_ref_hs;
  logic                  w_tick;

  assign w_hs       = (r_state == S_ISSUE) && r_cmd_valid && cmd_ready_i;
  assign w_ref_hs   = w_hs && (r_op == c_OP_REF);
  assign w_tick     = enable_i && (r_timer == c_TMR_LAST);
  assign w_grant_wr = (w_grant_op == c_OP_WR);

  // Grant priority: urgent refresh, batched rd/wr, single rd/wr, lazy refresh.
  always_comb begin
    w_grant    = 1'b0;
    w_grant_op = c_OP_RD;
    if (r_ref_pend >= c_URGENT) begin
      w_grant    = 1'b1;
      w_grant_op = c_OP_REF;
    end else if (rd_req_i && wr_req_i) begin
      w_grant = 1'b1;
      if (r_run < c_MAX_RUN) begin
        w_grant_op = r_last_wr ? c_OP_WR : c_OP_RD;
      end else begin
        w_grant_op = r_last_wr ? c_OP_RD : c_OP_WR;
      end
    end else if (rd_req_i) begin
      w_grant    = 1'b1;
      w_grant_op = c_OP_RD;
    end else if (wr_req_i) begin
      w_grant    = 1'b1;
      w_grant_op = c_OP_WR;
    end else if (r_ref_pend != 4'd0) begin
      w_grant    = 1'b1;
      w_grant_op = c_OP_REF;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    wr_ack_o    = 1'b0;
    rd_ack_o    = 1'b0;
    case (r_state)
      S_IDLE:  if (w_grant) w_state_nxt = S_ISSUE;
      S_ISSUE: if (w_hs) w_state_nxt = S_ACK;
      S_ACK: begin
        w_state_nxt = S_IDLE;
        wr_ack_o    = (r_op == c_OP_WR);
        rd_ack_o    = (r_op == c_OP_RD);
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cmd_valid <= 1'b0;
      r_op        <= c_OP_RD;
      r_tid       <= '0;
      r_adr       <= '0;
      r_last_wr   <= 1'b0;
      r_run       <= '0;
    end else if ((r_state == S_IDLE) && w_grant) begin
      r_cmd_valid <= 1'b1;
      r_op        <= w_grant_op;
      r_tid       <= (w_grant_op == c_OP_WR) ? wr_tid_i :
                     (w_grant_op == c_OP_RD) ? rd_tid_i : '0;
      r_adr       <= (w_grant_op == c_OP_WR) ? wr_adr_i :
                     (w_grant_op == c_OP_RD) ? rd_adr_i : '0;
      if (w_grant_op != c_OP_REF) begin
        if (w_grant_wr == r_last_wr) begin
          if (r_run != c_MAX_RUN) r_run <= r_run + c_RUN_W'(1);
        end else begin
          r_run     <= c_RUN_W'(1);
          r_last_wr <= w_grant_wr;
        end
      end
    end else if (w_hs) begin
      r_cmd_valid <= 1'b0;
    end
  end

  // A tick and a refresh handshake in the same cycle cancel out.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_timer    <= '0;
      r_ref_pend <= 4'd0;
      r_ref_err  <= 1'b0;
    end else if (!enable_i) begin
      r_timer    <= '0;
      r_ref_pend <= 4'd0;
    end else begin
      r_timer <= w_tick ? '0 : r_timer + c_TMR_W'(1);
      case ({w_tick, w_ref_hs})
        2'b10: begin
          if (r_ref_pend == c_PEND_MAX) r_ref_err  <= 1'b1;
          else                          r_ref_pend <= r_ref_pend + 4'd1;
        end
        2'b01: if (r_ref_pend != 4'd0) r_ref_pend <= r_ref_pend - 4'd1;
        default: ;
      endcase
    end
  end

  assign cmd_valid_o = r_cmd_valid;
  assign cmd_op_o    = r_op;
  assign cmd_tid_o   = r_tid;
  assign cmd_adr_o   = r_adr;
  assign ref_pend_o  = r_ref_pend;
  assign ref_err_o   = r_ref_err;

endmodule
`default_nettype wire

// File: tb/tb_ddr3_req_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ddr3_req_sched                                             |
// | Purpose  : Directed bench with a cycle-level scheduler reference model.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_ddr3_req_sched;

  localparam int ADDR_BITS = 25;
  localparam int ID_WIDTH  = 4;
  localparam int REFI      = 16;
  localparam int MAX_RUN   = 4;
  localparam int URGENT    = 4;

  logic                 clock, reset_n, enable;
  logic                 wr_req, wr_ack, rd_req, rd_ack;
  logic [ID_WIDTH-1:0]  wr_tid, rd_tid, cmd_tid;
  logic [ADDR_BITS-1:0] wr_adr, rd_adr, cmd_adr;
  logic                 cmd_valid, cmd_ready;
  logic [1:0]           cmd_op;
  logic [3:0]           ref_pend;
  logic                 ref_err;

  int  n_checks = 0;
  int  n_errors = 0;
  bit  ready_auto = 1'b0;

  ddr3_req_sched #(
    .ADDR_BITS(ADDR_BITS), .ID_WIDTH(ID_WIDTH), .REFI_CYCLES(REFI),
    .MAX_RUN(MAX_RUN), .REF_URGENT(URGENT)
  ) dut (
    .clock(clock), .reset_n(reset_n), .enable_i(enable),
    .wr_req_i(wr_req), .wr_ack_o(wr_ack), .wr_tid_i(wr_tid), .wr_adr_i(wr_adr),
    .rd_req_i(rd_req), .rd_ack_o(rd_ack), .rd_tid_i(rd_tid), .rd_adr_i(rd_adr),
    .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready), .cmd_op_o(cmd_op),
    .cmd_tid_o(cmd_tid), .cmd_adr_o(cmd_adr),
    .ref_pend_o(ref_pend), .ref_err_o(ref_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: op 0=read 1=write 2=refresh; phase 0=idle 1=issue 2=ack.
  int m_phase = 0, m_op = 0, m_tid = 0, m_adr = 0;
  int m_last = 0, m_run = 0, m_pend = 0, m_timer = 0;
  bit m_err = 1'b0;

  always @(posedge clock) begin : p_model
    int  g_op;
    bit  hs, tick, ref_hs;
    if (!reset_n) begin
      m_phase = 0; m_op = 0; m_tid = 0; m_adr = 0;
      m_last = 0; m_run = 0; m_pend = 0; m_timer = 0; m_err = 1'b0;
    end else begin
      hs     = (m_phase == 1) && cmd_ready;
      tick   = enable && (m_timer == REFI - 1);
      ref_hs = hs && (m_op == 2);
      if (m_phase == 0) begin
        g_op = -1;
        if (m_pend >= URGENT)      g_op = 2;
        else if (rd_req && wr_req) g_op = (m_run < MAX_RUN) ? m_last : 1 - m_last;
        else if (rd_req)           g_op = 0;
        else if (wr_req)           g_op = 1;
        else if (m_pend > 0)       g_op = 2;
        if (g_op >= 0) begin
          m_phase = 1;
          m_op    = g_op;
          m_tid   = (g_op == 0) ? int'(rd_tid) : (g_op == 1) ? int'(wr_tid) : 0;
          m_adr   = (g_op == 0) ? int'(rd_adr) : (g_op == 1) ? int'(wr_adr) : 0;
          if (g_op != 2) begin
            if (g_op == m_last) m_run = (m_run < MAX_RUN) ? m_run + 1 : MAX_RUN;
            else begin m_run = 1; m_last = g_op; end
          end
        end
      end else if (m_phase == 1) begin
        if (hs) m_phase = 2;
      end else begin
        m_phase = 0;
      end
      if (!enable) begin
        m_timer = 0; m_pend = 0;
      end else begin
        m_timer = tick ? 0 : m_timer + 1;
        if (tick && !ref_hs) begin
          if (m_pend == 8) m_err = 1'b1; else m_pend++;
        end else if (ref_hs && !tick) begin
          m_pend--;
        end
      end
    end
    #1;
    check("valid", int'(cmd_valid), int'(m_phase == 1));
    if (m_phase == 1) begin
      check("op", int'(cmd_op), m_op);
      check("tid", int'(cmd_tid), m_tid);
      check("adr", int'(cmd_adr), m_adr);
    end
    check("wr_ack", int'(wr_ack), int'(m_phase == 2 && m_op == 1));
    check("rd_ack", int'(rd_ack), int'(m_phase == 2 && m_op == 0));
    check("ref_pend", int'(ref_pend), m_pend);
    check("ref_err", int'(ref_err), int'(m_err));
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clock);
      if (ready_auto) cmd_ready = !(cmd_valid && cmd_op == 2'b10);
    end
  endtask

  task automatic idle_inputs();
    wr_req = 0; rd_req = 0; wr_tid = '0; rd_tid = '0; wr_adr = '0; rd_adr = '0;
    enable = 0; cmd_ready = 1; ready_auto = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset_n = 0;
    step(2);
    check("rst_valid", int'(cmd_valid), 0);
    check("rst_pend", int'(ref_pend), 0);
    check("rst_err", int'(ref_err), 0);
    check("rst_acks", int'({wr_ack, rd_ack}), 0);
    reset_n = 1;
  endtask

  initial begin : p_stim
    int exp_seq [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    int got [$];
    int cyc;
    reset_n = 0;
    idle_inputs();
    apply_reset();

    // Single write, refresh disabled
    wr_req = 1; wr_tid = 4'd3; wr_adr = 25'h12345;
    step();
    check("t1_valid", int'(cmd_valid), 1);
    check("t1_op", int'(cmd_op), 1);
    check("t1_tid", int'(cmd_tid), 3);
    check("t1_adr", int'(cmd_adr), 'h12345);
    step();
    check("t1_wr_ack", int'(wr_ack), 1);
    check("t1_rd_ack", int'(rd_ack), 0);
    wr_req = 0;
    step();
    check("t1_wr_ack_gone", int'(wr_ack), 0);
    step(2);

    // Batched arbitration: R R R R W W W W R
    apply_reset();
    rd_req = 1; rd_tid = 4'd1; rd_adr = 25'h100;
    wr_req = 1; wr_tid = 4'd2; wr_adr = 25'h200;
    cyc = 0;
    while (got.size() < 9 && cyc < 60) begin
      step();
      cyc++;
      if (cmd_valid && cmd_ready) got.push_back(int'(cmd_op));
    end
    check("t2_grants_seen", got.size(), 9);
    for (int i = 0; i < got.size() && i < 9; i++) check("t2_grant_dir", got[i], exp_seq[i]);
    rd_req = 0; wr_req = 0;
    step(4);

    // Refresh with no traffic
    apply_reset();
    enable = 1;
    step(15);
    check("t3_pend_before_tick", int'(ref_pend), 0);
    step();
    check("t3_pend_after_tick", int'(ref_pend), 1);
    check("t3_no_cmd_yet", int'(cmd_valid), 0);
    step();
    check("t3_ref_valid", int'(cmd_valid), 1);
    check("t3_ref_op", int'(cmd_op), 2);
    check("t3_ref_tid", int'(cmd_tid), 0);
    step();
    check("t3_pend_drained", int'(ref_pend), 0);
    check("t3_no_ack", int'({wr_ack, rd_ack}), 0);
    step(40);
    enable = 0;
    step(2);

    // Tick coincident with refresh handshake at pend 2
    apply_reset();
    cmd_ready = 0;
    enable = 1;
    cyc = 0;
    while (ref_pend != 4'd2 && cyc < 100) begin step(); cyc++; end
    check("t4_reach_pend2", int'(ref_pend), 2);
    check("t4_ref_stuck", int'(cmd_valid && cmd_op == 2'b10), 1);
    step(15);
    cmd_ready = 1;
    step();
    check("t4_pend_held", int'(ref_pend), 2);
    check("t4_handshake_done", int'(cmd_valid), 0);
    step(10);
    enable = 0;
    step(2);

    // Urgent refresh preempting reads, then saturation and error
    apply_reset();
    ready_auto = 1'b1;
    rd_req = 1; rd_tid = 4'd5; rd_adr = 25'h777;
    enable = 1;
    cyc = 0;
    while (!(cmd_valid && cmd_op == 2'b10) && cyc < 200) begin step(); cyc++; end
    check("t5_preempt_seen", int'(cmd_valid && cmd_op == 2'b10), 1);
    check("t5_preempt_pend", int'(ref_pend), 4);
    cyc = 0;
    while (!ref_err && cyc < 200) begin step(); cyc++; end
    check("t5_err_set", int'(ref_err), 1);
    check("t5_pend_sat", int'(ref_pend), 8);
    ready_auto = 1'b0;
    cmd_ready = 1;
    step(60);
    check("t5_err_sticky", int'(ref_err), 1);
    rd_req = 0; enable = 0;
    step(4);

    // Reset during ISSUE, then read-first after release
    apply_reset();
    cmd_ready = 0;
    wr_req = 1; wr_tid = 4'd9; wr_adr = 25'h55;
    step(2);
    check("t6_wr_in_flight", int'(cmd_valid && cmd_op == 2'b01), 1);
    reset_n = 0;
    #1;
    check("t6_valid_dropped", int'(cmd_valid), 0);
    check("t6_no_ack", int'({wr_ack, rd_ack}), 0);
    step(2);
    rd_req = 1; rd_tid = 4'd4; rd_adr = 25'h66;
    cmd_ready = 1;
    reset_n = 1;
    step();
    check("t6_first_is_read", int'(cmd_valid && cmd_op == 2'b00), 1);
    check("t6_read_tid", int'(cmd_tid), 4);
    rd_req = 0; wr_req = 0;
    step(6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
